drlp_sld_feeder: RTL and testbench
==================================

// Module: drlp_sld_feeder
// PURPOSE
// Drives the sliding-window register file: fetches 48-bit image columns (6 rows x 8 bit) from the
// line buffer, emits one shift per column with the correct window mode, and presents a window
// valid/ready handshake to the PE array. Sits between the image line buffer and the window regfile.
// Produces all window positions of one image strip at stride 1, then pulses done.
// PARAMETERS
// DATA_WIDTH        8    bits per pixel
// ROW_NUM           6    rows per column word
// COL_DATA_WIDTH    48   DATA_WIDTH*ROW_NUM, width of one column word
// ADDR_WIDTH        10   line-buffer address width
// CNT_WIDTH         8    width of column/window counters
// PORTS
// i_clk          in   1               clock, all state on rising edge
// i_rst          in   1               synchronous active-high reset
// i_start        in   1               start pulse; sampled only in IDLE
// i_cfg_mode     in   2               window mode: 00=3 wide, 01=4, 10=5, 11=6 columns (K)
// i_cfg_3x3      in   1               mode 00 only: which 3x3 half is loaded (1=high, 0=low)
// i_cfg_base     in   ADDR_WIDTH      line-buffer address of first column
// i_cfg_cols     in   CNT_WIDTH       number of image columns in strip (N)
// o_rd_en        out  1               line-buffer read enable
// o_rd_addr      out  ADDR_WIDTH      line-buffer read address
// i_rd_data      in   COL_DATA_WIDTH  read data, valid exactly 1 cycle after o_rd_en
// o_data         out  COL_DATA_WIDTH  column to window regfile (= i_rd_data, combinational)
// o_shift        out  1               shift strobe to window regfile
// o_mode         out  2               window mode to regfile (latched cfg)
// o_3x3          out  1               half select to regfile (latched cfg)
// o_win_valid    out  1               window in regfile is complete and stable
// i_win_ready    in   1               PE array consumes window
// o_busy         out  1               high in every state except IDLE
// o_done         out  1               1-cycle pulse at end of strip
// o_err          out  1               1-cycle pulse with o_done when N < K
// BEHAVIOUR
// - Reset: state IDLE; o_rd_en, o_shift, o_win_valid, o_busy, o_done, o_err = 0; o_rd_addr,
//   o_mode, o_3x3, counters = 0. Reset mid-strip aborts immediately, no done pulse.
// - IDLE: on i_start latch mode/3x3/base/N; K = mode+3. If N<K -> DONE with o_err. Else -> FILL.
// - FILL: issue K consecutive reads (o_rd_en=1, addr = base, base+1, ...), one per cycle, no gaps.
//   o_shift = o_rd_en delayed 1 cycle, so shift k coincides with i_rd_data of read k.
//   After K-th shift cycle -> WAIT.
// - WAIT: o_win_valid=1, held until i_win_ready. Handshake completes on cycle with both high.
//   On handshake: if windows emitted == N-K+1 -> DONE; else -> SLIDE, deassert o_win_valid.
// - SLIDE: issue 1 read (next address), shift on following cycle, then -> WAIT. Window valid
//   reasserts the cycle after the shift (regfile has updated). Min 3 cycles between windows.
// - DONE: o_done=1 for one cycle (o_err with it if N<K), -> IDLE. o_busy drops in IDLE.
// - o_shift never asserted while o_win_valid=1; window contents stable while valid.
// - i_start while busy is ignored; cfg inputs only sampled at accepted start.
// - Address wraps modulo 2^ADDR_WIDTH; no error. N=0 treated as N<K.
// - Total shifts per strip = N; total windows = N-K+1; last read address = base+N-1.
// TESTING
// - mode 11, base 0, N=6, ready tied 1 -> 6 reads addr 0..5, 6 shifts, 1 window, done; 0 err.
// - mode 00, 3x3=1, N=8, ready=1 -> 8 shifts, 6 windows, o_3x3=1 throughout, done after 6th.
// - mode 10, N=7, ready low 5 cycles per window -> valid held, no shift while valid, 3 windows.
// - mode 01, N=3 -> o_done+o_err pulse 2 cycles after start, no o_rd_en, no o_shift.
// - base=1022 (ADDR_WIDTH 10), mode 00, N=4 -> addresses 1022,1023,0,1; 2 windows.
// - i_rst asserted mid-FILL -> next cycle all outputs 0, IDLE; i_start during busy ignored.

Source files
------------

// File: rtl/drlp_sld_feeder.sv
// Sliding-window feeder: streams line-buffer columns into the window regfile and
// hands each complete stride-1 window to the PE array with a valid/ready handshake.
module drlp_sld_feeder #(
   parameter int DATA_WIDTH     = 8,
   parameter int ROW_NUM        = 6,
   parameter int COL_DATA_WIDTH = DATA_WIDTH * ROW_NUM,
   parameter int ADDR_WIDTH     = 10,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_start,
   input  logic [1:0]                i_cfg_mode,
   input  logic                      i_cfg_3x3,
   input  logic [ADDR_WIDTH-1:0]     i_cfg_base,
   input  logic [CNT_WIDTH-1:0]      i_cfg_cols,
   output logic                      o_rd_en,
   output logic [ADDR_WIDTH-1:0]     o_rd_addr,
   input  logic [COL_DATA_WIDTH-1:0] i_rd_data,
   output logic [COL_DATA_WIDTH-1:0] o_data,
   output logic                      o_shift,
   output logic [1:0]                o_mode,
   output logic                      o_3x3,
   output logic                      o_win_valid,
   input  logic                      i_win_ready,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FILL  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_SLIDE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_THREE = CNT_WIDTH'(3);

   logic [2:0]            state_q, state_d;
   logic [1:0]            mode_q, mode_d;
   logic                  half_q, half_d;
   logic                  err_flag_q, err_flag_d;
   logic [CNT_WIDTH-1:0]  n_win_q, n_win_d;
   logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
   logic [CNT_WIDTH-1:0]  sh_cnt_q, sh_cnt_d;
   logic [CNT_WIDTH-1:0]  win_cnt_q, win_cnt_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  shift_q, shift_d;
   logic                  valid_q, valid_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [CNT_WIDTH-1:0]  k_cur;
   logic [CNT_WIDTH-1:0]  k_new;

   // Window width K = mode + 3, for the latched strip and for a start being accepted.
   assign k_cur = CNT_WIDTH'(mode_q) + CNT_THREE;
   assign k_new = CNT_WIDTH'(i_cfg_mode) + CNT_THREE;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      half_d     = half_q;
      err_flag_d = err_flag_q;
      n_win_d    = n_win_q;
      rd_cnt_d   = rd_cnt_q;
      sh_cnt_d   = sh_cnt_q;
      win_cnt_d  = win_cnt_q;
      rd_en_d    = 1'b0;
      rd_addr_d  = rd_addr_q;
      shift_d    = rd_en_q;
      valid_d    = valid_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               mode_d    = i_cfg_mode;
               half_d    = i_cfg_3x3;
               rd_cnt_d  = '0;
               sh_cnt_d  = '0;
               win_cnt_d = '0;
               if (i_cfg_cols < k_new) begin
                  err_flag_d = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  err_flag_d = 1'b0;
                  n_win_d    = i_cfg_cols - k_new + CNT_ONE;
                  rd_en_d    = 1'b1;
                  rd_addr_d  = i_cfg_base;
                  rd_cnt_d   = CNT_ONE;
                  state_d    = S_FILL;
               end
            end
         end
         S_FILL: begin
            if (rd_cnt_q < k_cur) begin
               rd_en_d   = 1'b1;
               rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
               rd_cnt_d  = rd_cnt_q + CNT_ONE;
            end
            if (shift_q) begin
               sh_cnt_d = sh_cnt_q + CNT_ONE;
               if (sh_cnt_q == k_cur - CNT_ONE) begin
                  state_d = S_WAIT;
                  valid_d = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (i_win_ready) begin
               valid_d   = 1'b0;
               win_cnt_d = win_cnt_q + CNT_ONE;
               if (win_cnt_q + CNT_ONE == n_win_q) begin
                  state_d = S_DONE;
               end else begin
                  rd_en_d   = 1'b1;
                  rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                  state_d   = S_SLIDE;
               end
            end
         end
         S_SLIDE: begin
            // Valid comes back only after the regfile has absorbed the new column.
            if (shift_q) begin
               state_d = S_WAIT;
               valid_d = 1'b1;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            err_d   = err_flag_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         mode_q     <= '0;
         half_q     <= 1'b0;
         err_flag_q <= 1'b0;
         n_win_q    <= '0;
         rd_cnt_q   <= '0;
         sh_cnt_q   <= '0;
         win_cnt_q  <= '0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         shift_q    <= 1'b0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         half_q     <= half_d;
         err_flag_q <= err_flag_d;
         n_win_q    <= n_win_d;
         rd_cnt_q   <= rd_cnt_d;
         sh_cnt_q   <= sh_cnt_d;
         win_cnt_q  <= win_cnt_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         shift_q    <= shift_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign o_rd_en     = rd_en_q;
   assign o_rd_addr   = rd_addr_q;
   assign o_data      = i_rd_data;
   assign o_shift     = shift_q;
   assign o_mode      = mode_q;
   assign o_3x3       = half_q;
   assign o_win_valid = valid_q;
   assign o_busy      = (state_q != S_IDLE);
   assign o_done      = done_q;
   assign o_err       = err_q;

endmodule

// File: tb/tb_drlp_sld_feeder.sv
// Scoreboard bench for drlp_sld_feeder: a line-buffer model answers reads, expected
// addresses/windows/done events are queued at stimulus time and checked by a monitor.
module tb_drlp_sld_feeder;

   localparam int AW = 10;
   localparam int CW = 48;

   typedef struct {
      logic [287:0] d;
      logic [1:0]   m;
      logic         h;
   } win_t;

   typedef struct {
      logic e;
      int   nsh;
   } done_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    cfg_mode;
   logic          cfg_3x3;
   logic [AW-1:0] cfg_base;
   logic [7:0]    cfg_cols;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [CW-1:0] rd_data;
   logic [CW-1:0] data;
   logic          shift;
   logic [1:0]    mode;
   logic          h3;
   logic          valid;
   logic          ready;
   logic          busy;
   logic          done;
   logic          err;

   always #5 clk = ~clk;

   drlp_sld_feeder dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_cfg_mode  (cfg_mode),
      .i_cfg_3x3   (cfg_3x3),
      .i_cfg_base  (cfg_base),
      .i_cfg_cols  (cfg_cols),
      .o_rd_en     (rd_en),
      .o_rd_addr   (rd_addr),
      .i_rd_data   (rd_data),
      .o_data      (data),
      .o_shift     (shift),
      .o_mode      (mode),
      .o_3x3       (h3),
      .o_win_valid (valid),
      .i_win_ready (ready),
      .o_busy      (busy),
      .o_done      (done),
      .o_err       (err)
   );

   logic [CW-1:0] mem [0:1023];
   win_t          exp_win[$];
   logic [AW-1:0] exp_addr[$];
   done_t         exp_done[$];
   logic [CW-1:0] hist[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int start_cyc = 0;
   int hs_cyc = 0;
   int exp_k = 3;
   int shifts = 0;
   bit first_win = 1'b0;
   bit prev_valid = 1'b0;
   bit prev_hs = 1'b0;

   // Line buffer: data only meaningful the cycle after a read; garbage otherwise.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
      else       rd_data <= CW'({$urandom, $urandom});
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [287:0] act, input logic [287:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a read, window or done.
   always @(negedge clk) begin
      logic [AW-1:0] a;
      win_t          w;
      done_t         d;
      logic [287:0]  act;
      if (rst) begin
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
      end else begin
         if (rd_en) begin
            if (exp_addr.size() == 0) check("rd_unexpected", 1, 0);
            else begin
               a = exp_addr.pop_front();
               check("rd_addr", rd_addr, a);
            end
         end
         if (shift) begin
            hist.push_back(data);
            shifts++;
            check("shift_while_valid", valid, 0);
         end
         if (prev_valid && !valid && !prev_hs) check("valid_dropped", 0, 1);
         if (valid && !prev_valid) begin
            if (first_win) check("first_win_latency", cyc - start_cyc, exp_k + 2);
            else           check("slide_latency", cyc - hs_cyc, 3);
            first_win = 1'b0;
         end
         if (valid && ready) begin
            if (exp_win.size() == 0) check("win_unexpected", 1, 0);
            else begin
               w   = exp_win.pop_front();
               act = '0;
               if (hist.size() >= exp_k)
                  for (int i = 0; i < exp_k; i++)
                     act[48*i +: 48] = hist[hist.size() - exp_k + i];
               check("win_data", act, w.d);
               check("win_mode", mode, w.m);
               check("win_3x3", h3, w.h);
            end
            hs_cyc = cyc;
         end
         if (done) begin
            if (exp_done.size() == 0) check("done_unexpected", 1, 0);
            else begin
               d = exp_done.pop_front();
               check("done_err", err, d.e);
               check("done_shifts", shifts, d.nsh);
               if (d.e) check("err_latency", cyc - start_cyc, 2);
               else     check("done_latency", cyc - hs_cyc, 2);
               check("leftover", exp_addr.size() + exp_win.size(), 0);
            end
         end else if (err) begin
            check("err_without_done", 1, 0);
         end
         prev_valid = valid;
         prev_hs    = valid && ready;
      end
   end

   // Reference: strip of N columns at stride 1 gives reads base..base+N-1 and
   // windows j = columns j..j+K-1 for j = 0..N-K.
   task automatic prepare(input logic [1:0] m, input logic h, input logic [AW-1:0] b, input int n);
      int   k;
      win_t w;
      k = int'(m) + 3;
      hist.delete();
      shifts    = 0;
      first_win = 1'b1;
      exp_k     = k;
      if (n >= k) begin
         for (int i = 0; i < n; i++) exp_addr.push_back(AW'(int'(b) + i));
         for (int j = 0; j <= n - k; j++) begin
            w.d = '0;
            for (int i = 0; i < k; i++) w.d[48*i +: 48] = mem[AW'(int'(b) + j + i)];
            w.m = m;
            w.h = h;
            exp_win.push_back(w);
         end
      end
      exp_done.push_back('{(n < k), (n < k) ? 0 : n});
   endtask

   task automatic pulse_start(input logic [1:0] m, input logic h, input logic [AW-1:0] b, input int n);
      @(posedge clk); #1;
      start     = 1'b1;
      cfg_mode  = m;
      cfg_3x3   = h;
      cfg_base  = b;
      cfg_cols  = 8'(n);
      start_cyc = cyc;
   endtask

   // rmode: 0 ready tied high, 1 random ready, 2 ready low for 5 valid cycles.
   task automatic run_strip(input logic [1:0] m, input logic h, input logic [AW-1:0] b,
                            input int n, input int rmode, input bit poke);
      bit fin;
      int wc;
      fin = 1'b0;
      wc  = 0;
      prepare(m, h, b, n);
      if (rmode == 0) ready = 1'b1;
      pulse_start(m, h, b, n);
      for (int t = 0; t < 3000 && !fin; t++) begin
         @(posedge clk); #1;
         start    = poke && (t == 2);
         cfg_mode = 2'($urandom);
         cfg_3x3  = 1'($urandom);
         cfg_base = AW'($urandom);
         cfg_cols = 8'($urandom_range(0, 20));
         case (rmode)
            0: ready = 1'b1;
            1: ready = 1'($urandom_range(0, 1));
            default: begin
               if (valid) begin
                  wc++;
                  ready = (wc > 5);
               end else begin
                  wc    = 0;
                  ready = 1'b0;
               end
            end
         endcase
         fin = (exp_done.size() == 0);
      end
      start = 1'b0;
      if (!fin) begin
         check("strip_timeout", 0, 1);
         exp_addr.delete();
         exp_win.delete();
         exp_done.delete();
      end
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = CW'({$urandom, $urandom});
      rst      = 1'b1;
      start    = 1'b0;
      cfg_mode = '0;
      cfg_3x3  = 1'b0;
      cfg_base = '0;
      cfg_cols = '0;
      ready    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {rd_en, rd_addr, shift, mode, h3, valid, busy, done, err}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_strip(2'd3, 1'b0, 10'd0,    6, 0, 1'b0);
      run_strip(2'd0, 1'b1, 10'd37,   8, 0, 1'b0);
      run_strip(2'd2, 1'b0, 10'd500,  7, 2, 1'b0);
      run_strip(2'd1, 1'b1, 10'd200,  3, 0, 1'b0);
      run_strip(2'd0, 1'b0, 10'd1022, 4, 0, 1'b0);
      run_strip(2'd1, 1'b0, 10'd300,  9, 1, 1'b1);
      run_strip(2'd0, 1'b1, 10'd12,   0, 1, 1'b0);

      // Abort mid-FILL: reset must clear everything with no done pulse afterwards.
      prepare(2'd3, 1'b1, 10'd100, 10);
      pulse_start(2'd3, 1'b1, 10'd100, 10);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("busy_in_fill", busy, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_outputs", {rd_en, rd_addr, shift, mode, h3, valid, busy, done, err}, 0);
      exp_addr.delete();
      exp_win.delete();
      exp_done.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("idle_after_abort", {busy, rd_en, valid}, 0);

      for (int r = 0; r < 10; r++) begin
         logic [1:0] m;
         int         n;
         m = 2'($urandom);
         n = $urandom_range(0, 14);
         run_strip(m, 1'($urandom), AW'($urandom), n, 1 + (r % 2),
                   (n >= int'(m) + 3) && ($urandom_range(0, 1) == 1));
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
